freq_channel_scanner: RTL and testbench

FREQ_CHANNEL_SCANNER -- requirements
Module: freq_channel_scanner

---
 rtl/freq_channel_scanner.sv | 201 ++++++++++++++++++++
 tb/tb_freq_channel_scanner.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_channel_scanner.sv
// Three-channel frequency scanner: rotates a single low-frequency meter across
// si_in[2:0], keeps a per-channel result/valid/timeout store and a display read port.
module freq_channel_scanner #(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [2:0]  si_in,
  input  logic [1:0]  disp_sel,
  output logic        meter_start,
  output logic        meter_si,
  input  logic        meter_done,
  input  logic [15:0] meter_bcd,
  input  logic [1:0]  meter_dp,
  output logic [1:0]  cur_ch,
  output logic [15:0] disp_bcd,
  output logic [1:0]  disp_dp,
  output logic        disp_valid,
  output logic [2:0]  timeout_flag
);

  localparam int unsigned NCH = 3;
  localparam int unsigned SW  = 8;
  localparam int unsigned TW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned BW  = 16;
  localparam int unsigned DW  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_START,
    ST_WAIT,
    ST_STORE,
    ST_NEXT
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [1:0]      ch_q, ch_d;
  logic            start_q, start_d;
  logic [BW-1:0]   cap_bcd_q, cap_bcd_d;
  logic [DW-1:0]   cap_dp_q, cap_dp_d;
  logic [BW-1:0]   bcd_q [NCH];
  logic [BW-1:0]   bcd_d [NCH];
  logic [DW-1:0]   dp_q  [NCH];
  logic [DW-1:0]   dp_d  [NCH];
  logic [NCH-1:0]  vld_q, vld_d;
  logic [NCH-1:0]  tf_q, tf_d;
  logic [NCH-1:0]  ch_oh;

  // One-hot of the selected channel, used for all per-channel updates
  always_comb begin
    ch_oh = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_q == 2'(i)) ch_oh[i] = 1'b1;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    ch_d      = ch_q;
    start_d   = 1'b0;
    cap_bcd_d = cap_bcd_q;
    cap_dp_d  = cap_dp_q;
    bcd_d     = bcd_q;
    dp_d      = dp_q;
    vld_d     = vld_q;
    tf_d      = tf_q;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end

      ST_SETTLE: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (cnt_q == SW'(SETTLE - 1)) begin
          state_d = ST_START;
          start_d = 1'b1;
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end

      ST_START: begin
        tmr_d   = '0;
        state_d = ST_WAIT;
      end

      // Result is captured on the done cycle itself; STORE only commits it
      ST_WAIT: begin
        if (meter_done) begin
          cap_bcd_d = meter_bcd;
          cap_dp_d  = meter_dp;
          state_d   = ST_STORE;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          tf_d    = tf_q | ch_oh;
          vld_d   = vld_q & ~ch_oh;
          state_d = ST_NEXT;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end

      ST_STORE: begin
        for (int i = 0; i < NCH; i++) begin
          if (ch_oh[i]) begin
            bcd_d[i] = cap_bcd_q;
            dp_d[i]  = cap_dp_q;
          end
        end
        vld_d   = vld_q | ch_oh;
        tf_d    = tf_q & ~ch_oh;
        state_d = ST_NEXT;
      end

      ST_NEXT: begin
        ch_d = (ch_q == 2'(NCH - 1)) ? 2'd0 : ch_q + 2'd1;
        if (en) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tmr_q     <= '0;
      ch_q      <= '0;
      start_q   <= 1'b0;
      cap_bcd_q <= '0;
      cap_dp_q  <= '0;
      vld_q     <= '0;
      tf_q      <= '0;
      for (int i = 0; i < NCH; i++) begin
        bcd_q[i] <= '0;
        dp_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      ch_q      <= ch_d;
      start_q   <= start_d;
      cap_bcd_q <= cap_bcd_d;
      cap_dp_q  <= cap_dp_d;
      vld_q     <= vld_d;
      tf_q      <= tf_d;
      for (int i = 0; i < NCH; i++) begin
        bcd_q[i] <= bcd_d[i];
        dp_q[i]  <= dp_d[i];
      end
    end
  end

  // Meter input mux follows the selected channel without a register stage
  always_comb begin
    case (ch_q)
      2'd0:    meter_si = si_in[0];
      2'd1:    meter_si = si_in[1];
      2'd2:    meter_si = si_in[2];
      default: meter_si = 1'b0;
    endcase
  end

  // Display read port; disp_sel=3 reads as an empty, invalid slot
  always_comb begin
    disp_bcd   = '0;
    disp_dp    = '0;
    disp_valid = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (disp_sel == 2'(i)) begin
        disp_bcd   = bcd_q[i];
        disp_dp    = dp_q[i];
        disp_valid = vld_q[i];
      end
    end
  end

  assign meter_start  = start_q;
  assign cur_ch       = ch_q;
  assign timeout_flag = tf_q;

endmodule

// File: tb/tb_freq_channel_scanner.sv
// Scoreboard bench for freq_channel_scanner: stimulus queues expected starts and
// per-measurement results; a monitor checks them when the DUT presents each event.
module tb_freq_channel_scanner;

  localparam int unsigned SETTLE  = 4;
  localparam int unsigned TIMEOUT = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [2:0]  si_in;
  logic [1:0]  disp_sel;
  logic        meter_start;
  logic        meter_si;
  logic        meter_done;
  logic [15:0] meter_bcd;
  logic [1:0]  meter_dp;
  logic [1:0]  cur_ch;
  logic [15:0] disp_bcd;
  logic [1:0]  disp_dp;
  logic        disp_valid;
  logic [2:0]  timeout_flag;

  freq_channel_scanner #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .en(en), .si_in(si_in), .disp_sel(disp_sel),
    .meter_start(meter_start), .meter_si(meter_si), .meter_done(meter_done),
    .meter_bcd(meter_bcd), .meter_dp(meter_dp), .cur_ch(cur_ch),
    .disp_bcd(disp_bcd), .disp_dp(disp_dp), .disp_valid(disp_valid),
    .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ch;
    logic [2:0]  tf;
    logic [3:0]  vld;
    logic [63:0] bcd;
    logic [7:0]  dp;
    int          lat;
  } res_t;

  typedef struct packed {
    logic [1:0] ch;
    int         lat;
  } st_t;

  typedef struct packed {
    int         d;
    logic [15:0] bcd;
    logic [1:0]  dp;
    logic        stray;
  } plan_t;

  res_t  res_q[$];
  st_t   start_q[$];
  plan_t plan_q[$];

  int errors = 0;
  int checks = 0;
  int starts = 0;

  // Stimulus-side reference state of the channel store
  logic [15:0] m_bcd [3];
  logic [1:0]  m_dp  [3];
  logic [2:0]  m_vld, m_tf;
  int          m_ch;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic res_t snap(input int lat);
    res_t r;
    r.ch  = 2'(m_ch);
    r.tf  = m_tf;
    r.vld = {1'b0, m_vld};
    r.bcd = {16'h0, m_bcd[2], m_bcd[1], m_bcd[0]};
    r.dp  = {2'b0, m_dp[2], m_dp[1], m_dp[0]};
    r.lat = lat;
    return r;
  endfunction

  task automatic push_start(input int slat);
    st_t s;
    s.ch  = 2'(m_ch);
    s.lat = slat;
    start_q.push_back(s);
  endtask

  task automatic meas_ok(input int d, input logic [15:0] b, input logic [1:0] p,
                         input logic stray, input int slat);
    plan_t pl;
    push_start(slat);
    pl.d = d; pl.bcd = b; pl.dp = p; pl.stray = stray;
    plan_q.push_back(pl);
    m_bcd[m_ch]  = b;
    m_dp[m_ch]   = p;
    m_vld[m_ch]  = 1'b1;
    m_tf[m_ch]   = 1'b0;
    m_ch         = (m_ch == 2) ? 0 : m_ch + 1;
    res_q.push_back(snap(d + 3));
  endtask

  task automatic meas_to(input int slat);
    plan_t pl;
    push_start(slat);
    pl.d = 0; pl.bcd = 16'h0; pl.dp = 2'd0; pl.stray = 1'b0;
    plan_q.push_back(pl);
    m_tf[m_ch]  = 1'b1;
    m_vld[m_ch] = 1'b0;
    m_ch        = (m_ch == 2) ? 0 : m_ch + 1;
    res_q.push_back(snap(TIMEOUT + 2));
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_bcd[i] = 16'h0;
      m_dp[i]  = 2'd0;
    end
    m_vld = 3'b000;
    m_tf  = 3'b000;
    m_ch  = 0;
  endtask

  // Behavioural meter: answers each start according to the next plan entry
  initial begin
    plan_t p;
    meter_done = 1'b0;
    meter_bcd  = 16'h0;
    meter_dp   = 2'd0;
    forever begin
      @(negedge clk);
      if (meter_start === 1'b1 && reset === 1'b0 && plan_q.size() > 0) begin
        p = plan_q.pop_front();
        if (p.d > 0) begin
          repeat (p.d) @(negedge clk);
          meter_done = 1'b1;
          meter_bcd  = p.bcd;
          meter_dp   = p.dp;
          @(negedge clk);
          meter_done = 1'b0;
          meter_bcd  = 16'hDEAD;
          meter_dp   = 2'd1;
          if (p.stray) begin
            repeat (3) @(negedge clk);
            meter_done = 1'b1;
            meter_bcd  = 16'hFFFF;
            meter_dp   = 2'd3;
            @(negedge clk);
            meter_done = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: checks start pulses and every channel-advance / reset-release snapshot
  initial begin
    int   cyc = 0, rel_cyc = 0, st_cyc = 0, nev = 0;
    logic prev_rst = 1'b0, chk_w = 1'b0;
    logic [1:0] prev_ch = 2'd0;
    res_t e;
    st_t  s;
    disp_sel = 2'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset === 1'b1) begin
        prev_rst = 1'b1;
        prev_ch  = cur_ch;
        chk_w    = 1'b0;
        continue;
      end
      if (chk_w) chk("start_width", 64'(meter_start), 64'(0));
      chk_w = 1'b0;
      if (prev_rst || cur_ch != prev_ch) begin
        if (prev_rst) rel_cyc = cyc;
        prev_rst = 1'b0;
        prev_ch  = cur_ch;
        nev++;
        if (res_q.size() == 0) begin
          chk($sformatf("ev%0d_unexpected", nev), 64'(1), 64'(0));
        end else begin
          e = res_q.pop_front();
          chk($sformatf("ev%0d_cur_ch", nev), 64'(cur_ch), 64'(e.ch));
          chk($sformatf("ev%0d_tflag", nev), 64'(timeout_flag), 64'(e.tf));
          chk($sformatf("ev%0d_start", nev), 64'(meter_start), 64'(0));
          chk($sformatf("ev%0d_meter_si", nev), 64'(meter_si), 64'(si_in[e.ch]));
          if (e.lat != 0) chk($sformatf("ev%0d_latency", nev), 64'(cyc - st_cyc), 64'(e.lat));
          for (int sl = 0; sl < 4; sl++) begin
            disp_sel = 2'(sl);
            #1;
            chk($sformatf("ev%0d_bcd%0d", nev, sl), 64'(disp_bcd), 64'(e.bcd[16*sl +: 16]));
            chk($sformatf("ev%0d_dp%0d", nev, sl), 64'(disp_dp), 64'(e.dp[2*sl +: 2]));
            chk($sformatf("ev%0d_valid%0d", nev, sl), 64'(disp_valid), 64'(e.vld[sl]));
          end
          disp_sel = 2'd0;
        end
      end
      if (meter_start === 1'b1) begin
        starts++;
        st_cyc = cyc;
        chk_w  = 1'b1;
        if (start_q.size() == 0) begin
          chk($sformatf("start%0d_unexpected", starts), 64'(1), 64'(0));
        end else begin
          s = start_q.pop_front();
          chk($sformatf("start%0d_ch", starts), 64'(cur_ch), 64'(s.ch));
          if (s.lat != 0) chk($sformatf("start%0d_latency", starts), 64'(cyc - rel_cyc), 64'(s.lat));
        end
      end
    end
  end

  task automatic wait_starts(input int n, input int lim);
    int k = 0;
    while (starts < n && k < lim) begin
      @(posedge clk);
      k++;
    end
    chk($sformatf("wait_starts_%0d", n), 64'(starts >= n), 64'(1));
  endtask

  task automatic wait_drain(input int lim);
    int k = 0;
    while (res_q.size() != 0 && k < lim) begin
      @(posedge clk);
      k++;
    end
    chk("wait_drain", 64'(res_q.size()), 64'(0));
  endtask

  // Stimulus
  initial begin
    reset = 1'b1;
    en    = 1'b0;
    si_in = 3'b101;
    model_clear();
    res_q.push_back(snap(0));

    meas_ok(20, 16'h1234, 2'd2, 1'b0, SETTLE + 1);
    meas_to(0);
    meas_ok(30, 16'h3333, 2'd1, 1'b1, 0);
    meas_ok(5, 16'h0011, 2'd0, 1'b0, 0);
    meas_ok(TIMEOUT, 16'h0222, 2'd3, 1'b0, 0);
    meas_ok(40, 16'h4567, 2'd2, 1'b0, 0);

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    en    = 1'b1;

    // Drop enable a few cycles into the sixth measurement's WAIT
    wait_starts(6, 4000);
    repeat (5) @(posedge clk);
    #1;
    en = 1'b0;
    wait_drain(200);
    repeat (50) @(posedge clk);
    chk("starts_after_en_drop", 64'(starts), 64'(6));

    // Restart, then reset in the middle of an unanswered WAIT
    #1;
    meas_to(0);
    void'(res_q.pop_back());
    en = 1'b1;
    wait_starts(7, 50);
    repeat (10) @(posedge clk);
    #1;
    en = 1'b0;
    model_clear();
    res_q.push_back(snap(0));
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);

    chk("res_q_left", 64'(res_q.size()), 64'(0));
    chk("start_q_left", 64'(start_q.size()), 64'(0));
    chk("starts_total", 64'(starts), 64'(7));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
